// File: rtl/pc_flow_checker.sv
// pc_flow_checker: checks fetch-PC flow against the previous cycle's PC controls.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_clr            synchronous clear of counters, sticky record and FSM (back to WARM)
//   i_pc             PC currently driven to fetch
//   i_pc_en          PC write enable this cycle (0 = stall)
//   i_pc_sel         next-PC source: 00 SEQ, 01 TARGET, 10 TRAP, 11 illegal
//   i_target         branch/jump target
//   i_trap_vec       trap vector
//   i_insn_len       1 = 32-bit instruction, 0 = 16-bit (only honoured when C_EXT=1)
//   o_err            one-cycle violation pulse
//   o_err_code       code of the violation (1 MISALIGN, 2 SEQ, 3 TARGET, 4 TRAP, 5 HOLD, 6 ILLEGAL_SEL)
//   o_err_sticky     set by the first error
//   o_first_pc       i_pc at the first error
//   o_first_code     code of the first error
//   o_chk_cnt        checked cycles (saturating)
//   o_err_cnt        errors (saturating)
module pc_flow_checker #(
    parameter int XLEN        = 32,
    parameter int C_EXT       = 0,
    parameter int CNT_W       = 16,
    parameter int STOP_ON_ERR = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic [XLEN-1:0]  i_pc,
    input  logic             i_pc_en,
    input  logic [1:0]       i_pc_sel,
    input  logic [XLEN-1:0]  i_target,
    input  logic [XLEN-1:0]  i_trap_vec,
    input  logic             i_insn_len,
    output logic             o_err,
    output logic [2:0]       o_err_code,
    output logic             o_err_sticky,
    output logic [XLEN-1:0]  o_first_pc,
    output logic [2:0]       o_first_code,
    output logic [CNT_W-1:0] o_chk_cnt,
    output logic [CNT_W-1:0] o_err_cnt
);
    typedef enum logic [1:0] {WARM, RUN, HALT} state_t;
    state_t state, state_nxt;
    logic [XLEN-1:0] h_pc, h_target, h_trap_vec, step, exp_pc;
    logic [1:0] h_sel;
    logic h_en, h_len, misalign, check, hit;
    logic [2:0] code;
    assign misalign = (C_EXT != 0) ? i_pc[0] : |i_pc[1:0];
    assign step = (C_EXT == 0 || h_len) ? XLEN'(4) : XLEN'(2);
    assign exp_pc = !h_en ? h_pc :
                    h_sel == 2'b01 ? {h_target[XLEN-1:1], 1'b0} :
                    h_sel == 2'b10 ? h_trap_vec : h_pc + step;
    // Priority: alignment, then illegal select, then the flow mismatch for the recorded source.
    assign code = misalign ? 3'd1 :
                  (h_en && h_sel == 2'b11) ? 3'd6 :
                  (i_pc == exp_pc) ? 3'd0 :
                  !h_en ? 3'd5 :
                  h_sel == 2'b00 ? 3'd2 :
                  h_sel == 2'b01 ? 3'd3 : 3'd4;
    always_comb begin
        check = state == RUN;
        hit = check && code != 3'd0;
        state_nxt = state == WARM ? RUN : (hit && STOP_ON_ERR != 0) ? HALT : state;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= WARM;
            h_pc         <= '0;
            h_en         <= 1'b0;
            h_sel        <= 2'b00;
            h_target     <= '0;
            h_trap_vec   <= '0;
            h_len        <= 1'b0;
            o_err        <= 1'b0;
            o_err_code   <= 3'd0;
            o_err_sticky <= 1'b0;
            o_first_pc   <= '0;
            o_first_code <= 3'd0;
            o_chk_cnt    <= '0;
            o_err_cnt    <= '0;
        end else if (i_clr) begin
            state        <= WARM;
            h_pc         <= '0;
            h_en         <= 1'b0;
            h_sel        <= 2'b00;
            h_target     <= '0;
            h_trap_vec   <= '0;
            h_len        <= 1'b0;
            o_err        <= 1'b0;
            o_err_code   <= 3'd0;
            o_err_sticky <= 1'b0;
            o_first_pc   <= '0;
            o_first_code <= 3'd0;
            o_chk_cnt    <= '0;
            o_err_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            h_pc       <= i_pc;
            h_en       <= i_pc_en;
            h_sel      <= i_pc_sel;
            h_target   <= i_target;
            h_trap_vec <= i_trap_vec;
            h_len      <= i_insn_len;
            o_err      <= hit;
            o_err_code <= hit ? code : 3'd0;
            if (check && !(&o_chk_cnt))
                o_chk_cnt <= o_chk_cnt + CNT_W'(1);
            if (hit && !(&o_err_cnt))
                o_err_cnt <= o_err_cnt + CNT_W'(1);
            if (hit && !o_err_sticky) begin
                o_err_sticky <= 1'b1;
                o_first_pc   <= i_pc;
                o_first_code <= code;
            end
        end
    end
endmodule

// File: tb/tb_pc_flow_checker.sv
// tb_pc_flow_checker: scoreboard bench for two checker configurations.
module tb_pc_flow_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;
    logic a_clr, a_en, a_len, b_clr, b_en, b_len;
    logic [1:0] a_sel, b_sel;
    logic [31:0] a_pc, a_tgt, a_trap, b_pc, b_tgt, b_trap;
    logic a_err, a_sticky, b_err, b_sticky;
    logic [2:0] a_code, a_fcode, b_code, b_fcode;
    logic [31:0] a_fpc, b_fpc;
    logic [15:0] a_chk, a_errc;
    logic [3:0] b_chk, b_errc;

    pc_flow_checker #(.XLEN(32), .C_EXT(1), .CNT_W(16), .STOP_ON_ERR(0)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(a_clr), .i_pc(a_pc), .i_pc_en(a_en),
        .i_pc_sel(a_sel), .i_target(a_tgt), .i_trap_vec(a_trap), .i_insn_len(a_len),
        .o_err(a_err), .o_err_code(a_code), .o_err_sticky(a_sticky), .o_first_pc(a_fpc),
        .o_first_code(a_fcode), .o_chk_cnt(a_chk), .o_err_cnt(a_errc));

    pc_flow_checker #(.XLEN(32), .C_EXT(0), .CNT_W(4), .STOP_ON_ERR(1)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(b_clr), .i_pc(b_pc), .i_pc_en(b_en),
        .i_pc_sel(b_sel), .i_target(b_tgt), .i_trap_vec(b_trap), .i_insn_len(b_len),
        .o_err(b_err), .o_err_code(b_code), .o_err_sticky(b_sticky), .o_first_pc(b_fpc),
        .o_first_code(b_fcode), .o_chk_cnt(b_chk), .o_err_cnt(b_errc));

    typedef struct {
        int          cyc;
        bit          d;
        int          f;
        logic [31:0] v;
        string       nm;
    } item_t;
    item_t q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] act(bit d, int f);
        case (f)
            0: return d ? 32'(b_err) : 32'(a_err);
            1: return d ? 32'(b_code) : 32'(a_code);
            2: return d ? 32'(b_sticky) : 32'(a_sticky);
            3: return d ? b_fpc : a_fpc;
            4: return d ? 32'(b_fcode) : 32'(a_fcode);
            5: return d ? 32'(b_chk) : 32'(a_chk);
            default: return d ? 32'(b_errc) : 32'(a_errc);
        endcase
    endfunction

    // Monitor: pops every expectation due at this cycle and compares.
    always @(negedge clk) begin
        while (q.size() != 0 && q[0].cyc <= cyc) begin
            item_t it;
            it = q.pop_front();
            checks++;
            if (it.cyc != cyc || act(it.d, it.f) !== it.v) begin
                errors++;
                $display("FAIL %s dut_%s cyc %0d: got 0x%0h expected 0x%0h", it.nm,
                         it.d ? "b" : "a", cyc, act(it.d, it.f), it.v);
            end
        end
    end

    task automatic chk(input bit d, input int f, input logic [31:0] v, input string nm);
        q.push_back('{cyc + 1, d, f, v, nm});
    endtask

    task automatic chk_zero(input bit d, input string nm);
        for (int f = 0; f < 7; f++) chk(d, f, 0, nm);
    endtask

    // Drives one cycle of controls (aux feeds both target and trap vector) and
    // expects the error pulse/code that the following edge must produce.
    task automatic step(input bit d, input bit clr, input logic [31:0] pc, input bit en,
                        input logic [1:0] sel, input logic [31:0] aux, input bit len,
                        input logic [2:0] ec, input string nm);
        @(posedge clk); #1;
        if (d) begin
            b_clr = clr; b_pc = pc; b_en = en; b_sel = sel; b_tgt = aux; b_trap = aux; b_len = len;
        end else begin
            a_clr = clr; a_pc = pc; a_en = en; a_sel = sel; a_tgt = aux; a_trap = aux; a_len = len;
        end
        chk(d, 0, 32'(ec != 0), {nm, " err"});
        chk(d, 1, 32'(ec), {nm, " code"});
    endtask

    initial begin
        rst_n = 1'b0;
        {a_clr, a_en, a_sel, a_pc, a_tgt, a_trap} = '0;
        {b_clr, b_en, b_sel, b_pc, b_tgt, b_trap} = '0;
        a_len = 1'b1;
        b_len = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_zero(0, "reset a");
        chk_zero(1, "reset b");
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 32'(4 * i), 1, 2'b00, 0, 1, 0, "seq");
            if (i == 0) rst_n = 1'b1;
        end
        chk(0, 5, 9, "seq chk_cnt");
        chk(0, 6, 0, "seq err_cnt");
        step(0, 0, 32'h28, 1, 2'b01, 32'h103, 1, 0, "tgt set");
        step(0, 0, 32'h102, 1, 2'b01, 32'h200, 1, 0, "tgt bit0");
        step(0, 0, 32'h104, 1, 2'b00, 0, 0, 3, "tgt bad");
        chk(0, 2, 1, "tgt sticky");
        chk(0, 3, 32'h104, "tgt first_pc");
        chk(0, 4, 3, "tgt first_code");
        chk(0, 6, 1, "tgt err_cnt");
        chk(0, 5, 12, "tgt chk_cnt");
        step(0, 0, 32'h106, 1, 2'b01, 32'h40, 1, 0, "c16 step");
        chk(0, 3, 32'h104, "first_pc kept");
        step(0, 0, 32'h40, 0, 2'b00, 0, 1, 0, "to stall");
        step(0, 0, 32'h44, 1, 2'b01, 32'hFFFF_FFFC, 1, 5, "hold");
        step(0, 0, 32'hFFFF_FFFC, 1, 2'b00, 0, 1, 0, "to top");
        step(0, 0, 32'h0, 1, 2'b00, 0, 1, 0, "wrap");
        step(0, 0, 32'h4, 1, 2'b10, 32'h80, 1, 0, "trap set");
        step(0, 0, 32'h80, 1, 2'b10, 32'h100, 1, 0, "trap ok");
        step(0, 0, 32'h120, 1, 2'b00, 0, 1, 4, "trap bad");
        step(0, 0, 32'h123, 1, 2'b11, 0, 1, 1, "misalign");
        step(0, 0, 32'h200, 1, 2'b00, 0, 1, 6, "illegal sel");
        chk(0, 5, 22, "a chk_cnt");
        chk(0, 6, 5, "a err_cnt");
        chk(0, 4, 3, "a first_code kept");
        step(0, 1, 32'h300, 1, 2'b00, 0, 1, 0, "a clr");
        chk_zero(0, "a clr state");
        step(0, 0, 32'h301, 1, 2'b00, 0, 1, 0, "a warm");
        chk(0, 5, 0, "a warm chk_cnt");
        step(0, 0, 32'h305, 1, 2'b00, 0, 1, 1, "a misalign2");
        chk(0, 3, 32'h305, "a first_pc2");
        chk(0, 4, 1, "a first_code2");
        chk(0, 5, 1, "a chk_cnt2");
        chk(0, 6, 1, "a err_cnt2");

        step(1, 1, 32'h0, 1, 2'b11, 0, 1, 0, "b clr");
        step(1, 0, 32'h0, 1, 2'b11, 0, 1, 0, "b warm");
        step(1, 0, 32'h6, 1, 2'b00, 0, 1, 1, "both faults");
        chk(1, 6, 1, "both err_cnt");
        chk(1, 5, 1, "both chk_cnt");
        chk(1, 3, 32'h6, "both first_pc");
        for (int i = 0; i < 5; i++) step(1, 0, 32'(7 + 2 * i), 0, 2'b11, 0, 1, 0, "halt1");
        chk(1, 6, 1, "halt1 err_cnt");
        chk(1, 5, 1, "halt1 chk_cnt");
        step(1, 1, 32'h10, 1, 2'b00, 0, 1, 0, "b clr2");
        chk_zero(1, "b clr2 state");
        step(1, 0, 32'h10, 1, 2'b00, 0, 1, 0, "b warm2");
        step(1, 0, 32'h14, 1, 2'b00, 0, 1, 0, "b seq ok");
        step(1, 0, 32'h20, 1, 2'b00, 0, 1, 2, "b seq bad");
        chk(1, 6, 1, "b seq err_cnt");
        for (int i = 0; i < 5; i++) step(1, 0, 32'(32'h40 + 8 * i), 1, 2'b00, 0, 1, 0, "halt2");
        chk(1, 6, 1, "halt2 err_cnt");
        chk(1, 5, 2, "halt2 chk_cnt");
        chk(1, 3, 32'h20, "halt2 first_pc");
        chk(1, 4, 2, "halt2 first_code");
        step(1, 1, 32'h100, 1, 2'b00, 0, 1, 0, "b clr3");
        chk_zero(1, "b clr3 state");
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 32'(32'h100 + 4 * i), 1, 2'b00, 0, 1, 0, "b clean");
            if (i == 3) chk(1, 5, 3, "b chk_cnt 3");
            if (i == 16) chk(1, 5, 15, "b chk_cnt sat");
            if (i == 19) chk(1, 5, 15, "b chk_cnt held");
        end
        step(1, 0, 32'h150, 0, 2'b00, 0, 1, 0, "pre rst stall");
        @(posedge clk); #1;
        rst_n = 1'b0;
        chk_zero(0, "mid rst a");
        chk_zero(1, "mid rst b");
        step(1, 0, 32'h88, 1, 2'b00, 0, 1, 0, "rst release");
        rst_n = 1'b1;
        step(1, 0, 32'h8C, 1, 2'b00, 0, 1, 0, "post rst");
        chk(1, 5, 1, "post rst chk_cnt");
        chk(1, 6, 0, "post rst err_cnt");
        chk(1, 2, 0, "post rst sticky");

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            $display("FAIL scoreboard drain: got %0d pending expected 0", q.size());
            errors += q.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pc_flow_checker.md
Name: pc_flow_checker

Overview:
Synthesizable, parametrised program-counter flow checker for the RV32I core and its successors. It samples the fetch PC and the PC-control inputs every cycle and checks alignment, sequential increment, jump/branch target, trap-vector entry and stall-hold behaviour. It reports per-cycle error pulses, a sticky first-failure record, and saturating check/error counters. The block is bound beside the PC register in both the singlecycle and pipelined benches, and can also be instantiated on FPGA builds for on-chip self-check.

Parameters:
XLEN, 32, width of PC and target buses
C_EXT, 0, 1 = compressed support: 2-byte alignment, sequential step of 2 or 4
CNT_W, 16, width of check and error counters (saturating)
STOP_ON_ERR, 0, 1 = stop checking after the first error and stay in HALT until cleared

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_clr  in  1  synchronous clear of counters, sticky record and FSM (back to WARM)
i_pc  in  XLEN  actual PC currently driven to fetch
i_pc_en  in  1  PC register write enable this cycle (0 = stall)
i_pc_sel  in  2  next-PC source: 00 SEQ, 01 TARGET, 10 TRAP, 11 illegal
i_target  in  XLEN  ALU/branch target for TARGET
i_trap_vec  in  XLEN  trap vector for TRAP
i_insn_len  in  1  1 = 32-bit instruction, 0 = 16-bit (ignored, treated as 1, when C_EXT=0)
o_err  out  1  one-cycle pulse: a violation was detected at the previous edge
o_err_code  out  3  code of the violation flagged by o_err (0 when o_err=0)
o_err_sticky  out  1  set on the first error, held until i_clr or reset
o_first_pc  out  XLEN  i_pc value at the first error
o_first_code  out  3  code of the first error
o_chk_cnt  out  CNT_W  number of cycles checked (saturating)
o_err_cnt  out  CNT_W  number of errors (saturating)

Behaviour:
- Reset, asynchronous: all outputs 0, FSM = WARM, history registers 0. i_clr gives the same result synchronously. i_clr has priority over a detection at the same edge.
- History registers capture the following at every edge: i_pc, i_pc_en, i_pc_sel, i_target, i_trap_vec, i_insn_len.
- Expected PC, computed from the history (h_*):
  - h_en=0: expected = h_pc (hold).
  - SEQ: expected = h_pc + (h_len ? 4 : 2), modulo 2^XLEN (wrap-around is legal).
  - TARGET: expected = h_target with bit0 forced 0.
  - TRAP: expected = h_trap_vec.
- Error codes, in priority order (only the highest is reported):
  - 1 MISALIGN: i_pc[1:0]!=0, or i_pc[0]!=0 when C_EXT=1.
  - 6 ILLEGAL_SEL: h_en=1 and h_sel=11.
  - 5 HOLD: h_en=0 and i_pc != h_pc.
  - 2 SEQ, 3 TARGET, 4 TRAP: i_pc != expected for the respective h_sel.
- FSM:
  - WARM: the first edge after reset or clear. Only the history is loaded; no flow check is made, and MISALIGN is also not checked. Always goes to RUN.
  - RUN: every edge performs a check. o_chk_cnt increments. On an error, o_err is pulsed and o_err_cnt increments. The first error loads o_first_pc/o_first_code and sets o_err_sticky. If STOP_ON_ERR=1, an error moves the FSM to HALT.
  - HALT: no checks, counters frozen, o_err held 0. Leaves only via i_clr (to WARM) or reset.
- Latency: a violation present at edge k sets o_err/o_err_code after edge k, and they clear after edge k+1 unless there is a new violation.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-run discards all state. The first edge after deassertion is WARM, so no false error is raised from stale history.

Test Plan:
- Reset, then SEQ with en=1 for 10 cycles from 0x0000_0000, PC +4 each cycle -> o_err never set, o_chk_cnt=9 (first edge is WARM), o_err_cnt=0.
- TARGET with i_target=0x0000_0103, next PC 0x0000_0102 (C_EXT=1) -> no error; then next PC 0x0000_0104 after TARGET 0x0000_0200 -> o_err=1, code 3, o_first_pc=0x0000_0104, sticky=1.
- Stall: en=0 at PC 0x40, next PC 0x44 -> code 5. PC at 0xFFFF_FFFC with SEQ, next PC 0x0 -> no error (wrap).
- Simultaneous faults: PC 0x0000_0006 (C_EXT=0) following an illegal sel=11 -> code 1 only, o_err_cnt +1.
- STOP_ON_ERR=1: inject a SEQ error, then 5 further bad cycles -> o_err_cnt=1, FSM HALT; i_clr -> all outputs 0, next good cycles are checked again.
- CNT_W=4: run 20 clean cycles -> o_chk_cnt=0xF and holds there; assert i_rst_n=0 mid-run with corrupt history -> no o_err in the first cycle after release.
